instruction_fetch: RTL and testbench

//  Consumes the PC value presented during phase PH_F. Runs one instruction-memory read per

---
 rtl/instruction_fetch_pkg.sv | 12 +
 rtl/instruction_fetch_if.sv | 12 +
 rtl/instruction_fetch_timeout_ctr.sv | 27 ++
 rtl/instruction_fetch.sv | 115 +++++++++++
 tb/tb_instruction_fetch.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared phase codes and instruction encodings for the fetch stage.
package instruction_fetch_pkg;

    localparam logic [4:0]  PH_F     = 5'b00001;
    localparam logic [4:0]  PH_D     = 5'b00010;
    localparam logic [31:0] INSN_NOP = 32'h0000_0000;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: single outstanding request, ack carries the data.
interface instruction_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/instruction_fetch_timeout_ctr.sv
// Saturating wait counter; hit flags the cycle in which the count reaches LIMIT (LIMIT >= 1).
module fetch_timeout_ctr #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LIMIT) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Asserted while the increment at this edge would take the count to LIMIT.
    assign hit = en && (cnt >= LIMIT - 8'd1);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one imem read per PH_F, result latched into IR, decode stalled while waiting.
//   state | meaning
//   IDLE  | no fetch since reset/halt
//   REQ   | read outstanding, waiting for imem_ack or timeout
//   DONE  | IR settled (data or NOP), waiting for next PH_F
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [7:0]  TIMEOUT  = 8'd255,
    parameter logic [31:0] NOP_INSN = INSN_NOP
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       hlt,
    input  logic [4:0]                 phase,
    input  logic [31:0]                pc,
    instruction_fetch_if.master        imem,
    output logic [31:0]                ir,
    output logic                       ir_valid,
    output logic                       fetch_stall,
    output logic                       fetch_fault
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e state_q, state_d;
    logic   start;
    logic   load_data;
    logic   load_nop;
    logic   fault_d;
    logic   tmo_hit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else if (hlt) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A PH_F seen while still in REQ is a sequencer protocol error and is dropped.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        load_data = 1'b0;
        load_nop  = 1'b0;
        fault_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (phase == PH_F) begin
                    start = 1'b1;
                    if (!word_aligned(pc)) begin
                        state_d  = DONE;
                        load_nop = 1'b1;
                        fault_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (imem.imem_ack) begin
                    state_d   = DONE;
                    load_data = 1'b1;
                end else if (tmo_hit) begin
                    state_d  = DONE;
                    load_nop = 1'b1;
                    fault_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fetch_timeout_ctr #(.LIMIT(TIMEOUT)) u_tmo (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (hlt || start),
        .en    (state_q == REQ && !imem.imem_ack),
        .hit   (tmo_hit)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            imem.imem_addr <= '0;
            ir             <= NOP_INSN;
            ir_valid       <= 1'b0;
            fetch_fault    <= 1'b0;
        end else if (hlt) begin
            imem.imem_addr <= '0;
            ir             <= NOP_INSN;
            ir_valid       <= 1'b0;
            fetch_fault    <= 1'b0;
        end else begin
            fetch_fault <= fault_d;
            if (start) begin
                imem.imem_addr <= pc;
                ir_valid       <= 1'b0;
            end
            if (load_data) begin
                ir       <= imem.imem_rdata;
                ir_valid <= 1'b1;
            end else if (load_nop) begin
                ir <= NOP_INSN;
            end
        end
    end

    // Registered-state based so the sequencer never sees a path from imem_ack.
    assign imem.imem_req = (state_q == REQ);
    assign fetch_stall   = (state_q == REQ) && (phase == PH_D);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic against a transaction-level model.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int          TMO  = 4;
    localparam logic [4:0]  PH_E = 5'b00100;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        hlt = 1'b0;
    logic [4:0]  phase = PH_E;
    logic [31:0] pc = '0;
    logic [31:0] ir;
    logic        ir_valid, fetch_stall, fetch_fault;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch_if imem_bus ();

    instruction_fetch #(.TIMEOUT(8'(TMO))) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .hlt         (hlt),
        .phase       (phase),
        .pc          (pc),
        .imem        (imem_bus),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .fetch_stall (fetch_stall),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // Reference: a fetch is either outstanding (with an elapsed-cycle count) or not.
    bit          m_busy   = 1'b0;
    int          m_waited = 0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_ir     = INSN_NOP;
    bit          m_valid  = 1'b0;
    bit          m_fault  = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst || hlt) begin
            m_busy <= 1'b0; m_waited <= 0; m_addr <= '0;
            m_ir <= INSN_NOP; m_valid <= 1'b0; m_fault <= 1'b0;
        end else begin
            m_fault <= 1'b0;
            if (m_busy) begin
                if (imem_bus.imem_ack) begin
                    m_ir <= imem_bus.imem_rdata; m_valid <= 1'b1; m_busy <= 1'b0;
                end else if (m_waited + 1 >= TMO) begin
                    m_ir <= INSN_NOP; m_fault <= 1'b1; m_busy <= 1'b0;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else if (phase == PH_F) begin
                m_addr  <= pc;
                m_valid <= 1'b0;
                if (pc % 4 != 0) begin
                    m_ir <= INSN_NOP; m_fault <= 1'b1;
                end else begin
                    m_busy <= 1'b1; m_waited <= 0;
                end
            end
        end
    end

    logic stall_seen, stall_exp;
    int   stall_cnt;

    // Drive one cycle's inputs at negedge, sample the combinational stall, then settle past the edge.
    task automatic step(input logic [4:0] ph, input logic [31:0] p, input logic ack,
                        input logic [31:0] rd, input logic h);
        phase = ph; pc = p; hlt = h;
        imem_bus.imem_ack = ack; imem_bus.imem_rdata = rd;
        #1;
        stall_seen = fetch_stall;
        stall_exp  = m_busy && (ph == PH_D);
        if (stall_seen === 1'b1) stall_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
        #3 n_rst = 1'b0;
        #9;
        n_checks++;
        if ({imem_bus.imem_req, imem_bus.imem_addr, ir, ir_valid, fetch_stall, fetch_fault}
            !== {1'b0, 32'h0, INSN_NOP, 3'b000})
            $display("FAIL reset_outputs: req=%b addr=%h ir=%h v=%b st=%b flt=%b, want all zero/NOP",
                     imem_bus.imem_req, imem_bus.imem_addr, ir, ir_valid, fetch_stall, fetch_fault);
        else n_pass++;
        @(negedge clk) n_rst = 1'b1;
        step(PH_F, 32'h200, 1'b0, '0, 1'b0);
        n_checks++;
        if (imem_bus.imem_req !== 1'b1) $display("FAIL reset_pre_req: got %b want 1", imem_bus.imem_req);
        else n_pass++;
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if ({imem_bus.imem_req, ir, ir_valid} !== {1'b0, INSN_NOP, 1'b0})
            $display("FAIL reset_async: req=%b ir=%h v=%b want 0/%h/0", imem_bus.imem_req, ir, ir_valid, INSN_NOP);
        else n_pass++;
        @(negedge clk) n_rst = 1'b1;
    endtask

    task automatic test_zero_wait();
        step(PH_F, 32'h100, 1'b0, '0, 1'b0);
        n_checks++;
        if (imem_bus.imem_addr !== 32'h100) $display("FAIL zw_addr: got %h want 00000100", imem_bus.imem_addr);
        else n_pass++;
        step(PH_D, 32'h104, 1'b1, 32'hDEAD_BEEF, 1'b0);
        n_checks++;
        if (stall_seen !== stall_exp) $display("FAIL zw_stall_ack_cycle: got %b want %b", stall_seen, stall_exp);
        else n_pass++;
        n_checks++;
        if ({ir, ir_valid, imem_bus.imem_req} !== {32'hDEAD_BEEF, 1'b1, 1'b0})
            $display("FAIL zw_ir: ir=%h v=%b req=%b want deadbeef/1/0", ir, ir_valid, imem_bus.imem_req);
        else n_pass++;
        step(PH_D, 32'h104, 1'b0, '0, 1'b0);
        n_checks++;
        if (stall_seen !== 1'b0) $display("FAIL zw_stall_after: got %b want 0", stall_seen);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [31:0] word;
        word = $urandom;
        step(PH_F, 32'h1000, 1'b0, '0, 1'b0);
        stall_cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            n_checks++;
            if (imem_bus.imem_addr !== 32'h1000) $display("FAIL ws_addr_stable[%0d]: got %h want 00001000", i, imem_bus.imem_addr);
            else n_pass++;
            step(PH_D, 32'h1004, i == 3, (i == 3) ? word : 32'h5555_5555, 1'b0);
        end
        step(PH_D, 32'h1004, 1'b0, '0, 1'b0);
        n_checks++;
        if (stall_cnt !== 3) $display("FAIL ws_stall_count: got %0d want 3", stall_cnt);
        else n_pass++;
        n_checks++;
        if ({ir, ir_valid} !== {word, 1'b1}) $display("FAIL ws_ir: got %h/%b want %h/1", ir, ir_valid, word);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        step(PH_F, 32'h102, 1'b0, '0, 1'b0);
        n_checks++;
        if ({imem_bus.imem_req, fetch_fault, ir, ir_valid} !== {1'b0, 1'b1, INSN_NOP, 1'b0})
            $display("FAIL mis_fault: req=%b flt=%b ir=%h v=%b want 0/1/%h/0",
                     imem_bus.imem_req, fetch_fault, ir, ir_valid, INSN_NOP);
        else n_pass++;
        step(PH_D, 32'h106, 1'b0, '0, 1'b0);
        n_checks++;
        if ({fetch_fault, imem_bus.imem_req} !== 2'b00)
            $display("FAIL mis_pulse_width: flt=%b req=%b want 0/0", fetch_fault, imem_bus.imem_req);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [31:0] word;
        step(PH_F, 32'h300, 1'b0, '0, 1'b0);
        stall_cnt = 0;
        for (int i = 0; i < TMO; i++) step(PH_D, 32'h304, 1'b0, '0, 1'b0);
        n_checks++;
        if ({fetch_fault, ir, imem_bus.imem_req, stall_cnt} !== {1'b1, INSN_NOP, 1'b0, TMO})
            $display("FAIL tmo_fault: flt=%b ir=%h req=%b stalls=%0d want 1/%h/0/%0d",
                     fetch_fault, ir, imem_bus.imem_req, stall_cnt, INSN_NOP, TMO);
        else n_pass++;
        step(PH_D, 32'h304, 1'b0, '0, 1'b0);
        n_checks++;
        if ({fetch_fault, stall_seen} !== 2'b00) $display("FAIL tmo_release: flt=%b stall=%b want 0/0", fetch_fault, stall_seen);
        else n_pass++;
        word = $urandom | 32'h1;
        step(PH_F, 32'h308, 1'b0, '0, 1'b0);
        for (int i = 1; i <= TMO; i++) step(PH_D, 32'h30C, i == TMO, word, 1'b0);
        n_checks++;
        if ({fetch_fault, ir, ir_valid} !== {1'b0, word, 1'b1})
            $display("FAIL tmo_ack_wins: flt=%b ir=%h v=%b want 0/%h/1", fetch_fault, ir, ir_valid, word);
        else n_pass++;
    endtask

    task automatic test_hlt();
        step(PH_F, 32'h400, 1'b0, '0, 1'b0);
        step(PH_D, 32'h404, 1'b0, '0, 1'b0);
        step(PH_D, 32'h404, 1'b0, '0, 1'b1);
        n_checks++;
        if ({imem_bus.imem_req, ir, imem_bus.imem_addr} !== {1'b0, INSN_NOP, 32'h0})
            $display("FAIL hlt_drop: req=%b ir=%h addr=%h want 0/%h/0", imem_bus.imem_req, ir, imem_bus.imem_addr, INSN_NOP);
        else n_pass++;
        step(PH_D, 32'h404, 1'b1, 32'h0000_CAFE, 1'b0);
        n_checks++;
        if ({ir, ir_valid, fetch_fault} !== {INSN_NOP, 1'b0, 1'b0})
            $display("FAIL hlt_late_ack: ir=%h v=%b flt=%b want %h/0/0", ir, ir_valid, fetch_fault, INSN_NOP);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [4:0]  ph;
        logic [31:0] p;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3))
                0:       ph = PH_F;
                1, 2:    ph = PH_D;
                default: ph = PH_E;
            endcase
            p = {$urandom_range(32'h3FFF), 2'b00};
            if ($urandom_range(7) == 0) p[1:0] = 2'($urandom_range(3));
            step(ph, p, $urandom_range(3) == 0, $urandom, $urandom_range(31) == 0);
            n_checks++;
            if (stall_seen !== stall_exp) $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall_seen, stall_exp);
            else n_pass++;
            n_checks++;
            if ({imem_bus.imem_req, imem_bus.imem_addr, ir, ir_valid, fetch_fault}
                !== {m_busy, m_addr, m_ir, m_valid, m_fault})
                $display("FAIL rnd_outputs[%0d]: got req=%b addr=%h ir=%h v=%b flt=%b want %b/%h/%h/%b/%b", i,
                         imem_bus.imem_req, imem_bus.imem_addr, ir, ir_valid, fetch_fault,
                         m_busy, m_addr, m_ir, m_valid, m_fault);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_misaligned();
        test_timeout();
        test_hlt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
